ether_seq: RTL and testbench

- Host-side sequencer for the Ethernet core, sitting between the bus register file and the Ethernet module.
- Drives the core's 10-bit mode word, including the txrdy/rxdone handshake bits.
- Runs independent transmit and receive handshake FSMs against the core's status/error byte, with TX timeout.
- Generates the periodic MDIO status-poll event.

---
 rtl/ether_seq.sv | 193 +++++++++++++++++++
 tb/tb_ether_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_seq.sv
// ============================================================================
//  Module   : ether_seq
//  Purpose  : Host-side sequencer for the Ethernet core. Builds the core mode
//             word, runs the TX/RX handshakes against the synchronized status
//             byte and generates the periodic MDIO poll event.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ether_seq #(
    parameter int TX_TIMEOUT = 65535,
    parameter int POLL_DIV   = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  mode_i,
    input  logic        tx_start_i,
    input  logic [10:0] tx_len_i,
    output logic        tx_busy_o,
    output logic        tx_done_o,
    output logic [1:0]  tx_stat_o,
    input  logic        rx_ack_i,
    output logic        rx_rdy_o,
    output logic [10:0] rx_len_o,
    output logic [1:0]  rx_stat_o,
    input  logic        irq_clr_i,
    output logic        irq_o,
    input  logic [7:0]  sts_errs_i,
    input  logic [10:0] rxcntb_i,
    output logic [9:0]  ethmode_o,
    output logic [10:0] txcntb_o,
    output logic        md_evt_o
);

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_REQ  = 2'd1;
    localparam logic [1:0] T_ACK  = 2'd2;
    localparam logic [1:0] T_FIN  = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_PEND = 2'd1;
    localparam logic [1:0] R_DONE = 2'd2;

    localparam logic [15:0] TX_LAST   = 16'(TX_TIMEOUT - 1);
    localparam logic [16:0] POLL_LAST = 17'(POLL_DIV - 1);

    logic [7:0]  sts_m;
    logic [7:0]  sts_s;
    logic [5:0]  mode_lo;
    logic [1:0]  mode_hi;
    logic [1:0]  tx_state;
    logic [1:0]  rx_state;
    logic [15:0] tx_timer;
    logic        tx_irq;
    logic [16:0] poll_cnt;
    logic        txrdy;
    logic        rxdone;

    // crs, crs_err and mdc_err are synchronized but not used by the sequencer
    logic        unused_sts;
    assign unused_sts = ^{sts_s[7], sts_s[4], sts_s[3]};

    // Two-flop synchronizer for the asynchronous core status byte
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sts_m <= '0;
            sts_s <= '0;
        end else begin
            sts_m <= sts_errs_i;
            sts_s <= sts_m;
        end
    end

    // Mode word copy; loop/setup bits are frozen while a transmit is active
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_lo <= '0;
            mode_hi <= '0;
        end else begin
            mode_lo[0] <= mode_i[0];
            mode_lo[5] <= mode_i[5];
            mode_hi    <= mode_i[7:6];
            if (tx_state == T_IDLE) begin
                mode_lo[4:1] <= mode_i[4:1];
            end
        end
    end

    // Transmit handshake FSM with timeout and completion interrupt flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state  <= T_IDLE;
            tx_timer  <= '0;
            txcntb_o  <= '0;
            tx_stat_o <= '0;
            tx_irq    <= 1'b0;
        end else begin
            if (irq_clr_i) begin
                tx_irq <= 1'b0;
            end
            case (tx_state)
                T_IDLE: begin
                    if (tx_start_i) begin
                        txcntb_o  <= tx_len_i;
                        tx_stat_o <= '0;
                        tx_irq    <= 1'b0;
                        tx_timer  <= '0;
                        // A zero-length request completes without touching the core
                        tx_state  <= (tx_len_i == 11'd0) ? T_FIN : T_REQ;
                    end
                end
                T_REQ: begin
                    tx_timer <= tx_timer + 16'd1;
                    if (sts_s[5]) begin
                        tx_stat_o[0] <= sts_s[2];
                        tx_state     <= T_ACK;
                    end else if (tx_timer == TX_LAST) begin
                        tx_stat_o[1] <= 1'b1;
                        tx_state     <= T_ACK;
                    end
                end
                T_ACK: begin
                    if (!sts_s[5]) begin
                        tx_state <= T_FIN;
                    end
                end
                T_FIN: begin
                    // Placed after the clear so a coincident clear loses
                    tx_irq   <= 1'b1;
                    tx_state <= T_IDLE;
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Receive handshake FSM; pending frame survives rx_ena deassertion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state  <= R_IDLE;
            rx_rdy_o  <= 1'b0;
            rx_len_o  <= '0;
            rx_stat_o <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (mode_lo[0] && sts_s[6]) begin
                        rx_len_o  <= rxcntb_i;
                        rx_stat_o <= {sts_s[1], sts_s[0]};
                        rx_rdy_o  <= 1'b1;
                        rx_state  <= R_PEND;
                    end
                end
                R_PEND: begin
                    if (rx_ack_i) begin
                        rx_rdy_o <= 1'b0;
                        rx_state <= R_DONE;
                    end
                end
                R_DONE: begin
                    if (!sts_s[6]) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Free-running MDIO poll divider; pulse lands POLL_DIV cycles after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            poll_cnt <= '0;
            md_evt_o <= 1'b0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
            md_evt_o <= 1'b1;
        end else begin
            poll_cnt <= poll_cnt + 17'd1;
            md_evt_o <= 1'b0;
        end
    end

    assign txrdy     = (tx_state == T_REQ);
    assign rxdone    = (rx_state == R_DONE);
    assign tx_busy_o = (tx_state != T_IDLE);
    assign tx_done_o = (tx_state == T_FIN);
    assign irq_o     = rx_rdy_o | tx_irq;
    assign ethmode_o = {mode_hi, rxdone, txrdy, mode_lo};

endmodule

`default_nettype wire

// File: tb/tb_ether_seq.sv
// ============================================================================
//  Module   : tb_ether_seq
//  Purpose  : Directed self-checking bench for ether_seq (TX_TIMEOUT=100,
//             POLL_DIV=4) with a simple inline Ethernet core response model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ether_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mode = '0;
    logic        tx_start = 1'b0;
    logic [10:0] tx_len = '0;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  tx_stat;
    logic        rx_ack = 1'b0;
    logic        rx_rdy;
    logic [10:0] rx_len;
    logic [1:0]  rx_stat;
    logic        irq_clr = 1'b0;
    logic        irq;
    logic [7:0]  sts = '0;
    logic [10:0] rxcntb = '0;
    logic [9:0]  ethmode;
    logic [10:0] txcntb;
    logic        md_evt;

    int n_checks = 0;
    int n_fail   = 0;

    ether_seq #(
        .TX_TIMEOUT (100),
        .POLL_DIV   (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mode_i     (mode),
        .tx_start_i (tx_start),
        .tx_len_i   (tx_len),
        .tx_busy_o  (tx_busy),
        .tx_done_o  (tx_done),
        .tx_stat_o  (tx_stat),
        .rx_ack_i   (rx_ack),
        .rx_rdy_o   (rx_rdy),
        .rx_len_o   (rx_len),
        .rx_stat_o  (rx_stat),
        .irq_clr_i  (irq_clr),
        .irq_o      (irq),
        .sts_errs_i (sts),
        .rxcntb_i   (rxcntb),
        .ethmode_o  (ethmode),
        .txcntb_o   (txcntb),
        .md_evt_o   (md_evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {23'd0, tx_busy, tx_done, tx_stat, rx_rdy, rx_len, rx_stat, irq,
                ethmode, txcntb, md_evt};
    endfunction

    // Core model: raise txdone (with optional tx_err) after 10 cycles of txrdy,
    // drop it once txrdy falls. Counts txrdy cycles and done pulses.
    task automatic run_tx(input bit respond, input bit err,
                          output int rdy_cyc, output int done_cyc);
        int hi;
        hi       = 0;
        rdy_cyc  = 0;
        done_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            tx_start = 1'b0;
            if (ethmode[6]) begin
                rdy_cyc++;
                hi++;
                if (respond && hi == 10) begin
                    sts[5] = 1'b1;
                    sts[2] = err;
                end
            end else if (sts[5]) begin
                sts[5] = 1'b0;
                sts[2] = 1'b0;
            end
            if (tx_done) done_cyc++;
            if (done_cyc > 0 && !tx_busy) break;
        end
    endtask

    initial begin
        int rdy_c;
        int done_c;
        int w;
        int done_at;
        int rdy_at;
        int txrdy_seen;
        logic [11:0] evt_mask;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        // ---------------- 1: normal TX ----------------
        tx_len   = 11'd64;
        tx_start = 1'b1;
        run_tx(1'b1, 1'b0, rdy_c, done_c);
        check("t1_txcntb", 64'(txcntb), 64'd64);
        check("t1_txrdy_cycles", 64'(rdy_c), 64'd12);
        check("t1_done_pulses", 64'(done_c), 64'd1);
        check("t1_stat", 64'(tx_stat), 64'd0);
        check("t1_irq_set", 64'(irq), 64'd1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t1_irq_clr", 64'(irq), 64'd0);

        // TX with core reporting tx_err
        tx_len   = 11'd300;
        tx_start = 1'b1;
        run_tx(1'b1, 1'b1, rdy_c, done_c);
        check("t1b_stat_err", 64'(tx_stat), 64'd1);
        check("t1b_txcntb", 64'(txcntb), 64'd300);

        // ---------------- 2: timeout ----------------
        tx_len   = 11'd10;
        tx_start = 1'b1;
        run_tx(1'b0, 1'b0, rdy_c, done_c);
        check("t2_txrdy_cycles", 64'(rdy_c), 64'd100);
        check("t2_done_pulses", 64'(done_c), 64'd1);
        check("t2_stat_timeout", 64'(tx_stat), 64'd2);

        // ---------------- 3: RX frame ----------------
        mode = 8'h01;
        tick();
        rx_ack = 1'b1;                    // ack outside R_PEND is ignored
        tick();
        rx_ack = 1'b0;
        check("t3_ack_idle_ignored", 64'(ethmode[7]), 64'd0);
        rxcntb = 11'd1518;
        sts[6] = 1'b1;
        sts[0] = 1'b1;
        w = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            w++;
            if (rx_rdy) break;
        end
        check("t3_rx_latency", 64'(w), 64'd3);
        check("t3_rx_len", 64'(rx_len), 64'd1518);
        check("t3_rx_stat", 64'(rx_stat), 64'd1);
        check("t3_irq_rx", 64'(irq), 64'd1);
        repeat (5) tick();
        check("t3_rx_hold", 64'(rx_rdy), 64'd1);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        check("t3_rx_rdy_clr", 64'(rx_rdy), 64'd0);
        check("t3_rxdone_high", 64'(ethmode[7]), 64'd1);
        repeat (3) tick();
        check("t3_rxdone_held", 64'(ethmode[7]), 64'd1);
        sts[6] = 1'b0;
        sts[0] = 1'b0;
        w = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            w++;
            if (!ethmode[7]) break;
        end
        check("t3_rxdone_drop", 64'(w), 64'd3);

        // ---------------- 4: simultaneous zero-length TX and RX ----------------
        tx_len     = 11'd0;
        tx_start   = 1'b1;
        rxcntb     = 11'd100;
        sts[6]     = 1'b1;
        sts[1]     = 1'b1;
        done_at    = 0;
        rdy_at     = 0;
        done_c     = 0;
        txrdy_seen = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tx_start = 1'b0;
            if (tx_done) begin
                done_c++;
                if (done_at == 0) done_at = i;
            end
            if (ethmode[6]) txrdy_seen++;
            if (rx_rdy && rdy_at == 0) rdy_at = i;
        end
        check("t4_done_at", 64'(done_at), 64'd1);
        check("t4_done_pulses", 64'(done_c), 64'd1);
        check("t4_no_txrdy", 64'(txrdy_seen), 64'd0);
        check("t4_rx_at", 64'(rdy_at), 64'd3);
        check("t4_rx_len_stat", 64'({rx_len, rx_stat}), 64'({11'd100, 2'b10}));
        check("t4_txcntb", 64'(txcntb), 64'd0);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        sts[6] = 1'b0;
        sts[1] = 1'b0;
        repeat (4) tick();
        check("t4_rx_clean", 64'({rx_rdy, ethmode[7]}), 64'd0);
        check("t4_tx_irq", 64'(irq), 64'd1);

        // ---------------- 5: mode freeze during TX, pending survives rx_ena drop ----------------
        tx_len   = 11'd5;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("t5_irq_clr_by_start", 64'(irq), 64'd0);
        check("t5_txrdy", 64'(ethmode[6]), 64'd1);
        rxcntb = 11'd7;
        sts[6] = 1'b1;
        repeat (4) tick();
        check("t5_rx_pending", 64'(rx_rdy), 64'd1);
        mode     = 8'h02;
        tx_len   = 11'd9;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (4) tick();
        check("t5_start_ignored", 64'(txcntb), 64'd5);
        check("t5_iloop_frozen", 64'(ethmode[1:0]), 64'd0);
        check("t5_rx_kept", 64'(rx_rdy), 64'd1);
        run_tx(1'b1, 1'b0, rdy_c, done_c);
        check("t5_tx_done", 64'(done_c), 64'd1);
        check("t5_iloop_still_held", 64'(ethmode[1]), 64'd0);
        tick();
        check("t5_iloop_follows", 64'(ethmode[1]), 64'd1);
        check("t5_rx_still_pending", 64'({rx_rdy, rx_len}), 64'({1'b1, 11'd7}));
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        sts[6] = 1'b0;
        repeat (4) tick();

        // ---------------- 6: async reset mid-TX, then MDIO poll timing ----------------
        mode     = 8'h21;
        tx_len   = 11'd64;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (2) tick();
        check("t6_busy_before_rst", 64'({tx_busy, ethmode[6]}), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset", all_outs(), 64'd0);
        mode = 8'h00;
        sts  = '0;
        tick();
        rst = 1'b0;
        evt_mask = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            evt_mask[i] = md_evt;
        end
        check("t6_md_evt_pattern", 64'(evt_mask), 64'h888);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
